// File: rtl/tnn_pkg.sv
// Shared types and helpers for the input-spike scheduling logic.
package tnn_pkg;

  localparam int NUM_CH_DEF      = 8;
  localparam int TIME_PERIOD_DEF = 8;

  // Width of gamma time and spike_time: one bit more than needed to count
  // 0..TIME_PERIOD-1, so a spike_time of TIME_PERIOD or more is representable.
  function automatic int sched_tw(input int time_period);
    return $clog2(time_period) + 1;
  endfunction

  localparam int TW_DEF = sched_tw(TIME_PERIOD_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // One programmed channel: whether it fires this window, and when it stops.
  typedef struct packed {
    logic              en;
    logic [TW_DEF-1:0] spike_time;
  } ch_entry_t;

endpackage

// File: rtl/spike_sched_ctrl_spike_generation.sv
// Per-channel spike comparator: fires while the gamma time is below spike_time.
module spike_generation #(
  parameter int TW = tnn_pkg::TW_DEF
) (
  input  logic          should_spike,
  input  logic [TW-1:0] time_val,
  input  logic [TW-1:0] spike_time,
  output logic          spike
);

  // Unsigned compare: spike_time 0 never fires, large values fire all window.
  always_comb begin
    spike = should_spike && (spike_time > time_val);
  end

endmodule

// File: rtl/spike_sched_ctrl.sv
// Gamma-cycle sequencer: holds the per-channel {en, spike_time} bank, sweeps
// the shared time base for one window on start, and drives one spike train
// per channel toward the first TNN column.
//
// Load handshake: a write transfers on a rising clock edge where load_valid
// and load_ready are both high. load_ready depends only on registered state
// (high in IDLE), never on load_valid. The loader holds load_ch/load_en/
// load_time stable while load_valid is high; the write is visible the next
// cycle. Out-of-range channel indices are accepted and discarded.
module spike_sched_ctrl
  import tnn_pkg::*;
#(
  parameter  int NUM_CH      = NUM_CH_DEF,
  parameter  int TIME_PERIOD = TIME_PERIOD_DEF,
  localparam int TW          = sched_tw(TIME_PERIOD),
  localparam int CW          = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [CW-1:0]     load_ch,
  input  logic              load_en,
  input  logic [TW-1:0]     load_time,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              time_valid,
  output logic [TW-1:0]     time_val,
  output logic [NUM_CH-1:0] spike_vec,
  output logic              gamma_done,
  output sched_state_t      dbg_state
);

  localparam logic [TW-1:0] LAST_TIME = TW'(TIME_PERIOD - 1);

  sched_state_t    r_state;
  sched_state_t    w_state_next;
  logic [TW-1:0]   r_time_val;
  logic [TW-1:0]   w_time_next;
  ch_entry_t       r_bank [NUM_CH];
  logic            w_load_fire;
  logic            w_ch_ok;
  logic [NUM_CH-1:0] w_spike;

  assign w_load_fire = load_valid && load_ready;
  assign w_ch_ok     = (int'(load_ch) < NUM_CH);

  // Next state and next gamma time; clear overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_time_next  = '0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        if (r_time_val == LAST_TIME) w_state_next = DONE;
        else                         w_time_next  = r_time_val + TW'(1);
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (clear) begin
      w_state_next = IDLE;
      w_time_next  = '0;
    end
  end

  // State and time base registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_time_val <= '0;
    end else begin
      r_state    <= w_state_next;
      r_time_val <= w_time_next;
    end
  end

  // Channel bank: clear drops every enable but keeps spike_time; loads only
  // land in IDLE, so the bank is frozen for the whole window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_bank[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_bank[i].en <= 1'b0;
      end
    end else if (w_load_fire && w_ch_ok) begin
      r_bank[load_ch].en         <= load_en;
      r_bank[load_ch].spike_time <= load_time;
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state == RUN) || (r_state == DONE);
  assign time_valid = (r_state == RUN);
  assign gamma_done = (r_state == DONE);
  assign time_val   = r_time_val;
  assign dbg_state  = r_state;
  assign spike_vec  = w_spike;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_spike
    spike_generation #(.TW(TW)) u_spike_gen (
      .should_spike (r_bank[g].en && time_valid),
      .time_val     (r_time_val),
      .spike_time   (r_bank[g].spike_time),
      .spike        (w_spike[g])
    );
  end

endmodule

// File: tb/tb_spike_sched_ctrl.sv
// Self-checking bench for spike_sched_ctrl with a queue-based scoreboard.
module tb_spike_sched_ctrl;
  import tnn_pkg::*;

  localparam int NUM_CH = 8;
  localparam int TP     = 8;
  localparam int TW     = sched_tw(TP);
  localparam int CW     = $clog2(NUM_CH);
  localparam int W      = 1 + TW + NUM_CH;

  logic              clock;
  logic              reset_n;
  logic              load_valid;
  logic              load_ready;
  logic [CW-1:0]     load_ch;
  logic              load_en;
  logic [TW-1:0]     load_time;
  logic              start;
  logic              clear;
  logic              busy;
  logic              time_valid;
  logic [TW-1:0]     time_val;
  logic [NUM_CH-1:0] spike_vec;
  logic              gamma_done;
  sched_state_t      dbg_state;

  spike_sched_ctrl #(.NUM_CH(NUM_CH), .TIME_PERIOD(TP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_en    (load_en),
    .load_time  (load_time),
    .start      (start),
    .clear      (clear),
    .busy       (busy),
    .time_valid (time_valid),
    .time_val   (time_val),
    .spike_vec  (spike_vec),
    .gamma_done (gamma_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: channel bank and remaining busy cycles.
  logic          m_en   [NUM_CH];
  logic [TW-1:0] m_time [NUM_CH];
  int            run_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected window: one entry per gamma time, then the done pulse.
  task automatic push_run();
    logic [NUM_CH-1:0] vec;
    for (int t = 0; t < TP; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        vec[c] = m_en[c] && (int'(m_time[c]) > t);
      end
      exp_q.push_back({1'b0, TW'(t), vec});
    end
    exp_q.push_back({1'b1, {TW{1'b0}}, {NUM_CH{1'b0}}});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (time_valid || gamma_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got done=%0b time=%0d spikes=%0h, required no output",
                   gamma_done, time_val, spike_vec);
        end else begin
          check("window_output", 32'({gamma_done, time_val, spike_vec}), 32'(exp_q.pop_front()));
        end
      end else begin
        check("spike_outside_run", 32'(spike_vec), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // One clock of stimulus, entered and left at posedge+1.
  task automatic step(input logic lv, input logic [CW-1:0] ch, input logic le,
                      input logic [TW-1:0] lt, input logic st, input logic clr);
    load_valid = lv;
    load_ch    = ch;
    load_en    = le;
    load_time  = lt;
    start      = st;
    clear      = clr;
    #1;
    check("load_ready", 32'(load_ready), 32'(run_left == 0));
    check("busy", 32'(busy), 32'(run_left != 0));
    if (clr) begin
      for (int c = 0; c < NUM_CH; c++) m_en[c] = 1'b0;
      run_left = 0;
    end else if (run_left == 0) begin
      if (lv) begin
        m_en[ch]   = le;
        m_time[ch] = lt;
      end
      if (st) begin
        push_run();
        run_left = TP + 1;
      end
    end else begin
      run_left--;
    end
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    if (clr) exp_q.delete();
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic load(input int ch, input logic en, input int tm);
    step(1'b1, CW'(ch), en, TW'(tm), 1'b0, 1'b0);
  endtask

  // Busy cycles with ignored start/load noise sprinkled in.
  task automatic run_steps(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise && ($urandom_range(0, 2) == 0))
        step(1'b1, CW'($urandom_range(0, NUM_CH - 1)), 1'($urandom_range(0, 1)),
             TW'($urandom_range(0, (1 << TW) - 1)), 1'($urandom_range(0, 1)), 1'b0);
      else
        idle_step();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_ch    = '0;
    load_en    = 1'b0;
    load_time  = '0;
    start      = 1'b0;
    clear      = 1'b0;
    run_left   = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c]   = 1'b0;
      m_time[c] = '0;
    end

    #1 reset_n = 1'b0;
    #2;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spike_vec", 32'(spike_vec), 32'd0);
    check("rst_time_val", 32'(time_val), 32'd0);
    check("rst_time_valid", 32'(time_valid), 32'd0);
    check("rst_gamma_done", 32'(gamma_done), 32'd0);
    #19 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed bank: early stop, zero time, disabled, beyond-window time.
    load(0, 1'b1, 3);
    load(1, 1'b1, 0);
    load(2, 1'b0, 5);
    load(7, 1'b1, 9);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(4, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);      // start at time_val=4: ignored
    run_steps(3, 1'b0);
    step(1'b1, 3'd5, 1'b1, 4'd2, 1'b1, 1'b0);  // start+load during DONE: ignored
    idle_step();

    // Same-edge load+start; then loads during the run must not land.
    step(1'b1, 3'd3, 1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < TP + 1; i++) step(1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(TP + 1, 1'b0);

    // Abort at time_val=2, then an all-quiet window.
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(2, 1'b0);
    check("time_before_clear", 32'(time_val), 32'd2);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("state_after_clear", 32'(dbg_state), 32'(IDLE));
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(TP + 1, 1'b0);

    // clear beats load and start in the same IDLE cycle.
    load(0, 1'b1, 2);
    step(1'b1, 3'd0, 1'b1, 4'd6, 1'b1, 1'b1);
    idle_step();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(TP + 1, 1'b0);

    // Asynchronous reset in the middle of a window.
    load(4, 1'b1, 7);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_steps(3, 1'b0);
    check("time_before_reset", 32'(time_val), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_load_ready", 32'(load_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_spike_vec", 32'(spike_vec), 32'd0);
    check("mid_rst_time_val", 32'(time_val), 32'd0);
    check("mid_rst_gamma_done", 32'(gamma_done), 32'd0);
    exp_q.delete();
    run_left = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c]   = 1'b0;
      m_time[c] = '0;
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Randomized windows with occasional aborts.
    for (int it = 0; it < 30; it++) begin
      int n_ld;
      n_ld = $urandom_range(0, 4);
      for (int k = 0; k < n_ld; k++)
        load($urandom_range(0, NUM_CH - 1), 1'($urandom_range(0, 1)),
             $urandom_range(0, (1 << TW) - 1));
      step(1'($urandom_range(0, 1)), CW'($urandom_range(0, NUM_CH - 1)), 1'($urandom_range(0, 1)),
           TW'($urandom_range(0, (1 << TW) - 1)), 1'b1, 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 4) == 0) begin
        run_steps($urandom_range(0, TP), 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      end else begin
        run_steps(TP + 1, 1'b1);
      end
    end

    idle_step();
    idle_step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
